mipi_dsi_tx: RTL and testbench
==============================

// Module: mipi_dsi_tx
// PURPOSE
// Single-lane MIPI D-PHY transmitter (one clock lane, one data lane) for a DSI link.
// Sequences LP-11/LP-01/LP-00 entry, HS-zero, sync byte 0xB8, then serialises bytes LSB-first.
// Ends each burst with HS-trail and returns to LP-11. Sits between the DSI packet builder
// (d_in/d_req/b_req/d_ack byte bus) and the FPGA I/O buffers.
// PARAMETERS (all in clk cycles)
// T_LPX       4   duration of each LP-01 / LP-00 state, both lanes
// T_CLK_ZERO  16  clock-lane HS-0 time before the clock toggles
// T_CLK_PRE   8   clock toggling before the data lane may leave LP-11
// T_CLK_POST  16  clock toggling after data-lane EoT before the clock trail
// T_CLK_TRAIL 8   clock-lane HS-0 after the last toggle
// T_HS_ZERO   12  data-lane HS-0 time before the sync byte
// T_HS_TRAIL  8   data-lane trail (inverted last bit) after the last byte
// PORTS
// clk     in  1  system clock; all logic on rising edge
// rst     in  1  asynchronous reset, active-low (0 = reset)
// d_hs    out 1  data-lane HS serial bit
// c_hs    out 1  clock-lane HS signal
// d_lp_p  out 1  data-lane LP P wire     d_lp_n  out 1  data-lane LP N wire
// c_lp_p  out 1  clock-lane LP P wire    c_lp_n  out 1  clock-lane LP N wire
// d_in    in  8  byte to transmit, valid while d_req=1
// d_req   in  1  byte available on d_in
// b_req   in  1  bus request: keep the clock lane in HS while 1
// d_ack   out 1  one-cycle pulse: d_in sampled this edge
// BEHAVIOUR
// - Reset: all LP wires 1 (LP-11), d_hs=0, c_hs=0, d_ack=0, both FSMs idle. Reset at any point
//   aborts the burst immediately: no trail, outputs go straight to the reset values.
// - HS timing: one bit every 2 clk. c_hs toggles every 2 clk, offset 1 clk from data edges,
//   so each c_hs edge is centred in a bit (DDR). In LP states d_hs=c_hs=0.
// - Clock FSM: C_LP11 -(b_req=1)-> C_LP01 (T_LPX) -> C_LP00 (T_LPX) -> C_ZERO (T_CLK_ZERO, c_hs=0)
//   -> C_PRE (toggling, T_CLK_PRE) -> C_RUN. In C_RUN with b_req=0 and the data FSM in D_LP11:
//   -> C_POST (toggling, T_CLK_POST) -> C_TRAIL (c_hs=0, T_CLK_TRAIL) -> C_LP11.
//   A b_req=1 seen during C_POST or C_TRAIL is held and served after C_LP11.
// - Data FSM: D_LP11 -(clock in C_RUN, b_req=1, d_req=1)-> D_LP01 (T_LPX) -> D_LP00 (T_LPX)
//   -> D_ZERO (T_HS_ZERO, d_hs=0) -> D_SYNC (0xB8, LSB first: 0,0,0,1,1,1,0,1) -> D_DATA
//   -> D_TRAIL -> D_LP11.
// - LP wire encoding (p,n): LP11=(1,1), LP01=(0,1), LP00=(0,0); HS states drive (0,0).
// - Byte handshake: at the last clk of each byte slot (sync or data), if d_req=1 and b_req=1,
//   d_ack=1 for that single cycle, d_in is latched and becomes the next byte, gap-free.
//   If d_req=0 or b_req=0 at that point, no ack; go to D_TRAIL.
// - d_ack is never asserted outside a byte boundary and never 2 cycles in a row.
//   The requester must drop d_req or change d_in before the next boundary (16 clk).
// - D_TRAIL: d_hs = NOT(last transmitted bit) for T_HS_TRAIL clk, then LP-11.
//   A new burst may start from D_LP11 if b_req and d_req are both 1 again.
// - Simultaneous b_req fall and byte boundary: no ack, trail begins that cycle.
// - Counters width >= clog2(max parameter + 1); bit counter 3 bits, wraps 7->0 at byte load.
// TESTING
// 1 Reset held then released, b_req=0 -> all LP wires 1, d_hs=c_hs=0, d_ack=0 indefinitely.
// 2 b_req=1, d_req=1, d_in=0x80 -> clock LP01/LP00 for 4 clk each, 16 clk HS-0, toggle period 4 clk;
//   data LP01/LP00 4 clk each, 12 clk HS-0, bits 00011101, one d_ack at end of the sync slot.
// 3 Scenario 2, d_req dropped 5 clk after ack -> d_hs bits 00000001, then d_hs=0 (inverted 1)
//   for 8 clk, then data lane LP-11.
// 4 Re-raise d_req with 0x80 within 16 clk of each ack, two bytes -> 0xB8,0x80,0x80 contiguous.
//   Exactly 2 d_ack pulses, each 1 clk wide.
// 5 b_req=0 after last byte -> after data EoT, 16 clk toggling, 8 clk c_hs=0, clock lane LP-11.
//   Bench runs 500 ns more with no activity.
// 6 Reset asserted mid-data byte -> next cycle all LP wires 1, d_hs=c_hs=0, d_ack=0.

Source files
------------

// File: rtl/mipi_dsi_tx.sv
// -----------------------------------------------------------------------------
// mipi_dsi_tx
// Single-lane MIPI D-PHY transmitter for a DSI link: one clock lane and one
// data lane. Sequences the LP-11 -> LP-01 -> LP-00 entry, HS-zero, the 0xB8
// sync byte and then serialises payload bytes LSB first at one bit per two
// clk cycles. Each burst ends with an HS trail and a return to LP-11. The
// clock lane runs its own entry/exit sequence around the data bursts.
//
// Ports
//   clk              system clock, all logic on the rising edge
//   rst              asynchronous reset, active low (0 = reset)
//   d_in[7:0]        next payload byte, valid while d_req = 1
//   d_req            a byte is available on d_in
//   b_req            bus request: keep the clock lane in HS while 1
//   d_ack            one-cycle pulse: d_in is taken at this edge
//   d_hs             data-lane HS serial bit
//   c_hs             clock-lane HS signal (DDR, edges centred in data bits)
//   d_lp_p, d_lp_n   data-lane LP wires
//   c_lp_p, c_lp_n   clock-lane LP wires
//
// Timing parameters are in clk cycles. The phase alignment of the two lanes
// relies on 2*T_LPX + T_CLK_ZERO being a multiple of 4 and on
// 2*T_LPX + T_HS_ZERO being even (true for the defaults).
// -----------------------------------------------------------------------------
module mipi_dsi_tx #(
  parameter int T_LPX       = 4,
  parameter int T_CLK_ZERO  = 16,
  parameter int T_CLK_PRE   = 8,
  parameter int T_CLK_POST  = 16,
  parameter int T_CLK_TRAIL = 8,
  parameter int T_HS_ZERO   = 12,
  parameter int T_HS_TRAIL  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic       d_req,
  input  logic       b_req,
  output logic       d_ack,
  output logic       d_hs,
  output logic       c_hs,
  output logic       d_lp_p,
  output logic       d_lp_n,
  output logic       c_lp_p,
  output logic       c_lp_n
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int C_MAX = imax(imax(imax(T_LPX, T_CLK_ZERO), imax(T_CLK_PRE, T_CLK_POST)),
                              T_CLK_TRAIL);
  localparam int D_MAX = imax(imax(T_LPX, T_HS_ZERO), T_HS_TRAIL);
  localparam int C_CW  = $clog2(C_MAX + 1);
  localparam int D_CW  = $clog2(D_MAX + 1);

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {
    C_LP11, C_LP01, C_LP00, C_ZERO, C_PRE, C_RUN, C_POST, C_TRAIL
  } clk_state_t;

  typedef enum logic [2:0] {
    D_LP11, D_LP01, D_LP00, D_ZERO, D_SYNC, D_DATA, D_TRAIL
  } dat_state_t;

  clk_state_t      c_st, c_nxt;
  dat_state_t      d_st, d_nxt;
  logic [C_CW-1:0] c_cnt;
  logic [D_CW-1:0] d_cnt;
  logic            c_pend;
  logic [1:0]      tick;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            last_bit;
  logic            byte_end;
  logic            in_byte;

  // ---------------------------------------------------------------------------
  // Free-running bit-phase counter. A data bit occupies ticks {0,1} or {2,3};
  // data changes at edges where tick[0] = 1, the clock lane at edges where
  // tick[0] = 0, which puts every c_hs edge in the middle of a bit.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick <= 2'd0;
    else      tick <= tick + 2'd1;
  end

  // ---------------------------------------------------------------------------
  // Clock-lane FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_st   <= C_LP11;
      c_cnt  <= '0;
      c_pend <= 1'b0;
    end else begin
      c_st <= c_nxt;
      if (c_nxt != c_st || c_st == C_LP11 || c_st == C_RUN) c_cnt <= '0;
      else                                                  c_cnt <= c_cnt + 1'b1;
      // A bus request arriving while the lane is winding down (or while LP-11
      // waits for the start phase) is remembered and served from LP-11.
      if (c_nxt == C_LP01)
        c_pend <= 1'b0;
      else if (c_st == C_LP11 || c_st == C_POST || c_st == C_TRAIL)
        c_pend <= c_pend | b_req;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can leave it unassigned (latch).
  always_comb begin
    c_nxt = c_st;
    case (c_st)
      // Leaving on tick 0 makes C_PRE start with c_hs = 1 (24 cycles later).
      C_LP11:  if ((b_req || c_pend) && tick == 2'd0)        c_nxt = C_LP01;
      C_LP01:  if (c_cnt == C_CW'(T_LPX - 1))                c_nxt = C_LP00;
      C_LP00:  if (c_cnt == C_CW'(T_LPX - 1))                c_nxt = C_ZERO;
      C_ZERO:  if (c_cnt == C_CW'(T_CLK_ZERO - 1))           c_nxt = C_PRE;
      C_PRE:   if (c_cnt == C_CW'(T_CLK_PRE - 1))            c_nxt = C_RUN;
      C_RUN:   if (!b_req && d_st == D_LP11)                 c_nxt = C_POST;
      C_POST:  if (c_cnt == C_CW'(T_CLK_POST - 1))           c_nxt = C_TRAIL;
      C_TRAIL: if (c_cnt == C_CW'(T_CLK_TRAIL - 1))          c_nxt = C_LP11;
      default:                                                c_nxt = C_LP11;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-lane FSM
  // ---------------------------------------------------------------------------
  assign in_byte  = (d_st == D_SYNC) || (d_st == D_DATA);
  // Last clk of a byte slot: bit 7 in its second half-cycle.
  assign byte_end = in_byte && (bit_cnt == 3'd7) && tick[0];
  // A falling b_req on the boundary wins: no ack, the trail starts instead.
  assign d_ack    = byte_end && d_req && b_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_st  <= D_LP11;
      d_cnt <= '0;
    end else begin
      d_st <= d_nxt;
      if (d_nxt != d_st || d_st == D_LP11 || in_byte) d_cnt <= '0;
      else                                            d_cnt <= d_cnt + 1'b1;
    end
  end

  always_comb begin
    d_nxt = d_st;
    case (d_st)
      // Leaving on tick[0] = 1 aligns the sync byte with a bit boundary.
      D_LP11:  if (c_st == C_RUN && b_req && d_req && tick[0]) d_nxt = D_LP01;
      D_LP01:  if (d_cnt == D_CW'(T_LPX - 1))                  d_nxt = D_LP00;
      D_LP00:  if (d_cnt == D_CW'(T_LPX - 1))                  d_nxt = D_ZERO;
      D_ZERO:  if (d_cnt == D_CW'(T_HS_ZERO - 1))              d_nxt = D_SYNC;
      D_SYNC,
      D_DATA:  if (byte_end)                                   d_nxt = d_ack ? D_DATA : D_TRAIL;
      D_TRAIL: if (d_cnt == D_CW'(T_HS_TRAIL - 1))             d_nxt = D_LP11;
      default:                                                 d_nxt = D_LP11;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serialiser. shreg[0] is the bit on the wire; it shifts at the end of each
  // bit and reloads from d_in on an acknowledged boundary, so consecutive
  // bytes follow each other with no gap. bit_cnt wraps 7 -> 0 on that load.
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset too, so d_hs is defined in the
  // trail even if a burst is aborted and restarted without a reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      last_bit <= 1'b0;
    end else if (d_st == D_ZERO && d_nxt == D_SYNC) begin
      shreg   <= SYNC_BYTE;
      bit_cnt <= 3'd0;
    end else if (in_byte && tick[0]) begin
      last_bit <= shreg[0];
      bit_cnt  <= bit_cnt + 3'd1;
      shreg    <= d_ack ? d_in : {1'b0, shreg[7:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Lane outputs. HS states drive the LP wires to (0,0).
  // ---------------------------------------------------------------------------
  assign c_lp_p = (c_st == C_LP11);
  assign c_lp_n = (c_st == C_LP11) || (c_st == C_LP01);
  assign d_lp_p = (d_st == D_LP11);
  assign d_lp_n = (d_st == D_LP11) || (d_st == D_LP01);

  // tick 0,1,2,3 -> 0,1,1,0: period 4 clk, edges at tick 1 and tick 3.
  assign c_hs = ((c_st == C_PRE) || (c_st == C_RUN) || (c_st == C_POST)) &&
                (tick[1] ^ tick[0]);

  always_comb begin
    d_hs = 1'b0;
    case (d_st)
      D_SYNC, D_DATA: d_hs = shreg[0];
      D_TRAIL:        d_hs = ~last_bit;
      default:        d_hs = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mipi_dsi_tx.sv
// -----------------------------------------------------------------------------
// tb_mipi_dsi_tx
// Scoreboard bench for mipi_dsi_tx. The driver pushes the bytes it expects on
// the wire (sync byte plus every payload byte it offers for acknowledgement);
// a cycle monitor decodes both lanes, pops and compares each received byte and
// checks the LP/HS sequence lengths, bit timing and the trail.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mipi_dsi_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       d_req = 1'b0;
  logic       b_req = 1'b0;
  logic       d_ack, d_hs, c_hs, d_lp_p, d_lp_n, c_lp_p, c_lp_n;

  always #5 clk = ~clk;

  mipi_dsi_tx dut (
    .clk    (clk),
    .rst    (rst),
    .d_in   (d_in),
    .d_req  (d_req),
    .b_req  (b_req),
    .d_ack  (d_ack),
    .d_hs   (d_hs),
    .c_hs   (c_hs),
    .d_lp_p (d_lp_p),
    .d_lp_n (d_lp_n),
    .c_lp_p (c_lp_p),
    .c_lp_n (c_lp_n)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] plan[$];
  int         cyc = 0, acks = 0, bursts_done = 0, clk_done = 0, data_eot_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Lane monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_LP01, M_ZERO, M_BYTE, M_TRAIL} dmon_t;
  typedef enum {CM_IDLE, CM_LP01, CM_ZERO, CM_TOG} cmon_t;

  dmon_t       ms = M_IDLE;
  cmon_t       cs = CM_IDLE;
  int          mcnt = 0, k = 0, ddr_err = 0, zero_err = 0, trail_err = 0;
  int          ccnt = 0, pcnt = 0;
  logic [7:0]  rx = 8'h00, pat = 8'h00;
  logic [11:0] chist = '0;
  logic        prev_d = 1'b0, prev_c = 1'b0, prev_ack = 1'b0, exp_trail = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        ms = M_IDLE; cs = CM_IDLE; prev_ack = 1'b0; chist = '0;
      end else begin
        if (d_ack) begin
          acks++;
          check("ack_one_cycle", prev_ack, 1'b0);
          check("ack_at_boundary", (ms == M_BYTE && k == 15), 1'b1);
        end
        prev_ack = d_ack;

        // Data lane
        case (ms)
          M_IDLE: if ({d_lp_p, d_lp_n} == 2'b01) begin ms = M_LP01; mcnt = 1; end
          M_LP01: begin
            if ({d_lp_p, d_lp_n} == 2'b01) mcnt++;
            else begin
              check("d_lp01_len", mcnt, 4);
              ms = M_ZERO; mcnt = 1;
              zero_err = ({d_lp_p, d_lp_n} != 2'b00 || d_hs) ? 1 : 0;
            end
          end
          M_ZERO: begin
            // LP-00 (4) plus HS-zero (12): 16 cycles of (0,0) with d_hs = 0
            if (mcnt < 16) begin
              if ({d_lp_p, d_lp_n} != 2'b00 || d_hs) zero_err++;
              mcnt++;
            end else begin
              check("d_lp00_hs_zero", zero_err, 0);
              ms = M_BYTE; k = 0; rx = 8'h00; ddr_err = 0;
            end
          end
          M_TRAIL: begin
            if ({d_lp_p, d_lp_n} == 2'b00) begin
              mcnt++;
              if (d_hs !== exp_trail) trail_err++;
            end else begin
              check("d_trail_len", mcnt, 8);
              check("d_trail_bit", trail_err, 0);
              check("d_back_to_lp11", {d_lp_p, d_lp_n, d_hs}, 3'b110);
              data_eot_cyc = cyc;
              bursts_done++;
              ms = M_IDLE;
            end
          end
          default: ;
        endcase

        if (ms == M_BYTE) begin
          if ({d_lp_p, d_lp_n} != 2'b00) ddr_err++;
          if (k % 2 == 1) begin
            // bit held for 2 clk, clock edge in between
            if (d_hs !== prev_d || c_hs === prev_c) ddr_err++;
            rx[k / 2] = d_hs;
          end
          prev_d = d_hs;
          prev_c = c_hs;
          if (k == 15) begin
            check("bit_timing", ddr_err, 0);
            check("byte_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("byte_value", rx, exp_q.pop_front());
            if (exp_q.size() > 0) begin
              k = 0; ddr_err = 0;
            end else begin
              ms = M_TRAIL; exp_trail = ~rx[7]; mcnt = 0; trail_err = 0;
            end
          end else begin
            k++;
          end
        end

        // Clock lane
        case (cs)
          CM_IDLE: if ({c_lp_p, c_lp_n} == 2'b01) begin cs = CM_LP01; ccnt = 1; end
          CM_LP01: begin
            if ({c_lp_p, c_lp_n} == 2'b01) ccnt++;
            else begin
              check("c_lp01_len", ccnt, 4);
              cs = CM_ZERO; ccnt = 1;
            end
          end
          CM_ZERO: begin
            if (!c_hs) ccnt++;
            else begin
              // LP-00 (4) plus clock HS-zero (16)
              check("c_lp00_hs_zero_len", ccnt, 20);
              cs = CM_TOG; pat = 8'h01; pcnt = 1;
            end
          end
          CM_TOG: begin
            if ({c_lp_p, c_lp_n} == 2'b11) begin
              check("c_trail_low", chist[7:0], 8'h00);
              check("c_post_toggling", (chist[11] != chist[9]) && (chist[10] != chist[8]), 1'b1);
              check("c_post_trail_len", cyc - data_eot_cyc, 25);
              clk_done++;
              cs = CM_IDLE;
            end else if (pcnt < 8) begin
              pat[pcnt] = c_hs;
              pcnt++;
              // 1,1,0,0,1,1,0,0 : period 4 clk
              if (pcnt == 8) check("c_pre_pattern", pat, 8'h33);
            end
          end
          default: ;
        endcase
        chist = {chist[10:0], c_hs};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_outputs", {d_lp_p, d_lp_n, c_lp_p, c_lp_n, d_hs, c_hs, d_ack}, 7'b1111000);
    end
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (d_ack) got = 1'b1;
    end
    check("ack_seen", got, 1'b1);
  endtask

  // Sends plan[0..n-1]. With cut_b_req, another byte is offered after the
  // last one but b_req falls before the boundary, so it must not be taken.
  task automatic run_burst(input int n, input bit cut_b_req);
    int a0, bd0, cd0;
    bit got;
    a0 = acks; bd0 = bursts_done; cd0 = clk_done;
    exp_q.push_back(8'hB8);
    for (int i = 0; i < n; i++) begin
      d_in = plan[i]; d_req = 1'b1; b_req = 1'b1;
      exp_q.push_back(plan[i]);
      wait_ack(got);
      if (!got) break;
      if (i == n - 1) begin
        if (cut_b_req) begin
          repeat (2) @(posedge clk);
          #1 d_in = 8'hFF;
          repeat (3) @(posedge clk);
          #1 b_req = 1'b0;
        end else begin
          repeat (5) @(posedge clk);
          #1 d_req = 1'b0; b_req = 1'b0;
        end
      end else begin
        repeat (5) @(posedge clk);
        #1 d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 400 && (bursts_done == bd0 || clk_done == cd0); i++) @(negedge clk);
    check("burst_complete", (bursts_done > bd0) && (clk_done > cd0), 1'b1);
    check("ack_count", acks - a0, n);
    d_req = 1'b0; b_req = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bit got;
    // Reset held, then released with b_req = 0
    repeat (3) @(posedge clk);
    check("reset_outputs", {d_lp_p, d_lp_n, c_lp_p, c_lp_n, d_hs, c_hs, d_ack}, 7'b1111000);
    #1 rst = 1'b1;
    check_idle(10);

    // Single byte, d_req dropped 5 clk after ack
    plan = '{8'h80};
    run_burst(1, 1'b0);
    check_idle(4);

    // Two contiguous bytes after sync
    plan = '{8'h80, 8'h80};
    run_burst(2, 1'b0);

    // Mixed bytes, last bit 0 so the trail bit is 1
    plan = '{8'h5A, 8'hC3, 8'h01};
    run_burst(3, 1'b0);

    // b_req falls with d_req still high at the boundary: no ack, trail
    plan = '{8'h3C};
    run_burst(1, 1'b1);

    // Quiet bus for 500 ns
    check_idle(50);

    // Reset in the middle of a data byte
    d_in = 8'h80; d_req = 1'b1; b_req = 1'b1;
    exp_q.push_back(8'hB8);
    exp_q.push_back(8'h80);
    wait_ack(got);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_abort", {d_lp_p, d_lp_n, c_lp_p, c_lp_n, d_hs, c_hs, d_ack}, 7'b1111000);
    d_req = 1'b0; b_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("reset_hold", {d_lp_p, d_lp_n, c_lp_p, c_lp_n, d_hs, c_hs, d_ack}, 7'b1111000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
